// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared constants and types for the line-granular memory responder.
//   Holds the system line/address geometry, the default request/response
//   latencies, the line-offset width and the responder FSM state type.
package mem_responder_pkg;

  localparam int CACHE_LINE_LEN = 128;
  localparam int BYTE_LEN       = 8;
  localparam int ADDRESS_BITS   = 32;
  localparam int MEM_REQ_DELAY  = 5;
  localparam int MEM_RESP_DELAY = 5;

  // Byte-offset bits inside one line; these never select a line.
  localparam int LINE_OFF_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ_WAIT  = 2'd1,
    RESP_WAIT = 2'd2,
    RESP      = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_delay_counter.sv
// mem_delay_counter
//   Cycle counter shared by both wait states of the responder.
//   Ports:
//     clk, rst_n  clock and synchronous active-low reset
//     clear       force the count to zero on the next edge (wins over enable)
//     enable      count up by one each cycle
//     terminal    count value at which done is raised
//     count       current count
//     done        enable && count == terminal
module mem_delay_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         done
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign done = enable && (count == terminal);

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Single-outstanding line memory responder with fixed request and response
//   latencies. A request is latched on accept, the array is touched at the
//   last request-wait cycle, and the response is offered after the
//   response-wait cycles.
//   Handshake: a transfer happens on a rising edge where valid && ready; the
//   sender holds valid and its payload until that edge, and the receiver may
//   raise ready independently of valid.
//   Ports:
//     clk, rst_n                      clock, synchronous active-low reset
//     req_valid/req_ready             request handshake (ready only in IDLE)
//     req_we, req_addr, req_wdata     request payload (write flag, byte address, line)
//     resp_valid/resp_ready           response handshake
//     resp_data                       read line, or the written line for writes
//     resp_err                        address error flag (MEM_ERR_EN builds only)
//   Optional feature: define MEM_ERR_EN to flag misaligned or out-of-range
//   addresses instead of wrapping them.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH_LINES = 4096,
  parameter int REQ_DELAY       = MEM_REQ_DELAY,
  parameter int RESP_DELAY      = MEM_RESP_DELAY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDRESS_BITS-1:0]   req_addr,
  input  logic [CACHE_LINE_LEN-1:0] req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [CACHE_LINE_LEN-1:0] resp_data
`ifdef MEM_ERR_EN
  ,
  output logic                      resp_err
`endif
);

  localparam int IDX_W = $clog2(MEM_DEPTH_LINES);
  localparam int MAX_D = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
  localparam int CNT_W = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  mem_state_e state, state_next;

  logic                      lat_we;
  logic [IDX_W-1:0]          lat_idx;
  logic [CACHE_LINE_LEN-1:0] lat_wdata;
  logic                      lat_err;
  logic                      addr_err;

  logic             cnt_en, cnt_clear, cnt_done;
  logic [CNT_W-1:0] cnt_term, cnt_value;
  logic             access;

  logic [CACHE_LINE_LEN-1:0] mem [MEM_DEPTH_LINES];

`ifdef MEM_ERR_EN
  assign addr_err = (req_addr[LINE_OFF_BITS-1:0] != '0) ||
                    ((req_addr >> (LINE_OFF_BITS + IDX_W)) != '0);
`else
  // Offset and upper bits are ignored, so addresses wrap over the array.
  logic unused_addr;
  assign unused_addr = ^req_addr;
  assign addr_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    cnt_en     = 1'b0;
    cnt_term   = '0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_next = REQ_WAIT;
      end
      REQ_WAIT: begin
        cnt_en   = 1'b1;
        cnt_term = CNT_W'(REQ_DELAY - 1);
        if (cnt_done) begin
          access     = 1'b1;
          state_next = RESP_WAIT;
        end
      end
      RESP_WAIT: begin
        cnt_en   = 1'b1;
        cnt_term = CNT_W'(RESP_DELAY - 1);
        if (cnt_done) state_next = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Idle clears the count so each wait state starts at zero; the terminal
  // cycle clears it again for the following wait state.
  assign cnt_clear = !cnt_en || cnt_done;

  mem_delay_counter #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_term),
    .count    (cnt_value),
    .done     (cnt_done)
  );

  // Request capture only in IDLE, so busy-time req_valid cannot disturb it.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      lat_we    <= req_we;
      lat_idx   <= req_addr[LINE_OFF_BITS +: IDX_W];
      lat_wdata <= req_wdata;
      lat_err   <= addr_err;
    end
  end

  // Array has no reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && access && lat_we && !lat_err) begin
      mem[lat_idx] <= lat_wdata;
    end
  end

  // Response payload changes only at the access edge, so it holds while
  // the response waits for resp_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_data <= '0;
`ifdef MEM_ERR_EN
      resp_err  <= 1'b0;
`endif
    end else if (access) begin
      if (lat_err)     resp_data <= '0;
      else if (lat_we) resp_data <= lat_wdata;
      else             resp_data <= mem[lat_idx];
`ifdef MEM_ERR_EN
      resp_err  <= lat_err;
`endif
    end
  end

endmodule
